// File: rtl/core_pkg.sv
// Shared core definitions used by the reorder buffer.
// Provides machine widths, ROB geometry, the ROB entry record and the
// ROB retirement state encoding.
package core_pkg;

    localparam int XLEN        = 32;   // PC width
    localparam int LOG2_PREGS  = 7;    // physical register tag width
    localparam int ISSUE_WIDTH = 2;    // commit lanes
    localparam int ROB_ENTRIES = 64;   // power of 2
    localparam int LOG2_ROB    = $clog2(ROB_ENTRIES);

    typedef enum logic {
        RUN      = 1'b0,
        EXC_WAIT = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  exc;
        logic                  is_store;
        logic [4:0]            arch_rd;
        logic [LOG2_PREGS-1:0] phys_rd;
        logic [XLEN-1:0]       pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer between rename/dispatch and commit.
//   clk, reset (async, active-high)
//   alloc_*   : up to DISP_W program-ordered allocations per cycle; alloc_ready
//               and per-lane alloc_rob_idx are returned combinationally
//   wb_*      : WB_W writeback ports marking entries done (and faulting)
//   flush     : clears the whole buffer on the next edge
//   rob_commit_* : up to COMMIT_W completed head entries, exceptions on lane 0 only
//   rob_count / rob_empty / rob_full : occupancy
// After a faulting entry is presented for one cycle the buffer freezes
// (no commit, no allocation) until flush arrives.
module reorder_buffer
    import core_pkg::*;
#(
    parameter int ROB_ENTRIES = core_pkg::ROB_ENTRIES,
    parameter int DISP_W      = 2,
    parameter int WB_W        = 2,
    parameter int COMMIT_W    = core_pkg::ISSUE_WIDTH,
    parameter int PHYS_W      = core_pkg::LOG2_PREGS,
    parameter int XLEN        = core_pkg::XLEN,
    localparam int IDX_W      = $clog2(ROB_ENTRIES),
    localparam int CNT_W      = IDX_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DISP_W-1:0]   alloc_valid,
    input  logic [4:0]          alloc_arch_rd [DISP_W],
    input  logic [PHYS_W-1:0]   alloc_phys_rd [DISP_W],
    input  logic [XLEN-1:0]     alloc_pc [DISP_W],
    input  logic [DISP_W-1:0]   alloc_is_store,
    output logic                alloc_ready,
    output logic [IDX_W-1:0]    alloc_rob_idx [DISP_W],
    input  logic [WB_W-1:0]     wb_valid,
    input  logic [IDX_W-1:0]    wb_rob_idx [WB_W],
    input  logic [WB_W-1:0]     wb_exception,
    input  logic                flush,
    output logic [COMMIT_W-1:0] rob_commit_valid,
    output logic [4:0]          rob_commit_arch_rd [COMMIT_W],
    output logic [PHYS_W-1:0]   rob_commit_phys_rd [COMMIT_W],
    output logic [COMMIT_W-1:0] rob_commit_exception,
    output logic [IDX_W-1:0]    rob_commit_rob_idx [COMMIT_W],
    output logic [COMMIT_W-1:0] rob_commit_is_store,
    output logic [XLEN-1:0]     rob_commit_pc [COMMIT_W],
    output logic [CNT_W-1:0]    rob_count,
    output logic                rob_empty,
    output logic                rob_full
);

    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(ROB_ENTRIES - DISP_W);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ROB_ENTRIES);

    rob_entry_t              entries [ROB_ENTRIES];
    logic [IDX_W-1:0]        head_reg;
    logic [IDX_W-1:0]        tail_reg;
    logic [CNT_W-1:0]        count_reg;
    rob_state_e              state_reg;
    rob_state_e              state_next;

    logic [DISP_W-1:0]       alloc_fire;
    logic [IDX_W-1:0]        alloc_offset;
    logic [CNT_W-1:0]        n_alloc;
    logic [CNT_W-1:0]        n_commit;
    logic [COMMIT_W-1:0]     retire;
    logic                    commit_chain;
    logic [ROB_ENTRIES-1:0]  wb_set;
    logic [ROB_ENTRIES-1:0]  wb_exc;

    // Readiness is taken from the registered count only, so a commit in the
    // same cycle does not reopen allocation until the following cycle.
    assign alloc_ready = (state_reg == RUN) && (count_reg <= READY_MAX);
    assign rob_count   = count_reg;
    assign rob_empty   = (count_reg == '0);
    assign rob_full    = (count_reg == FULL_CNT);

    // Lanes compact: each lane takes the slot after the lower valid lanes.
    always_comb begin
        alloc_offset = '0;
        n_alloc      = '0;
        alloc_fire   = '0;
        for (int i = 0; i < DISP_W; i++) begin
            alloc_rob_idx[i] = tail_reg + alloc_offset;
            alloc_fire[i]    = alloc_valid[i] & alloc_ready;
            if (alloc_valid[i]) alloc_offset = alloc_offset + IDX_W'(1);
            if (alloc_fire[i])  n_alloc = n_alloc + CNT_W'(1);
        end
    end

    // A lane only retires if every older lane retired cleanly; a faulting
    // entry may only show up on lane 0 and never advances the head.
    always_comb begin
        commit_chain = (state_reg == RUN);
        n_commit     = '0;
        retire       = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            rob_commit_rob_idx[k]   = head_reg + IDX_W'(k);
            rob_commit_arch_rd[k]   = entries[rob_commit_rob_idx[k]].arch_rd;
            rob_commit_phys_rd[k]   = entries[rob_commit_rob_idx[k]].phys_rd;
            rob_commit_pc[k]        = entries[rob_commit_rob_idx[k]].pc;
            rob_commit_is_store[k]  = entries[rob_commit_rob_idx[k]].is_store;
            rob_commit_exception[k] = entries[rob_commit_rob_idx[k]].exc;
            rob_commit_valid[k]     = commit_chain
                                    & entries[rob_commit_rob_idx[k]].valid
                                    & entries[rob_commit_rob_idx[k]].done
                                    & ((k == 0) | ~entries[rob_commit_rob_idx[k]].exc);
            retire[k]    = rob_commit_valid[k] & ~rob_commit_exception[k];
            if (retire[k]) n_commit = n_commit + CNT_W'(1);
            commit_chain = retire[k];
        end
    end

    // Merge writeback ports per entry so two ports hitting one index OR together.
    always_comb begin
        wb_set = '0;
        wb_exc = '0;
        for (int p = 0; p < WB_W; p++) begin
            if (wb_valid[p]) begin
                wb_set[wb_rob_idx[p]] = 1'b1;
                wb_exc[wb_rob_idx[p]] = wb_exc[wb_rob_idx[p]] | wb_exception[p];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:      if (rob_commit_valid[0] && rob_commit_exception[0]) state_next = EXC_WAIT;
            EXC_WAIT: state_next = EXC_WAIT;
            default:  state_next = RUN;
        endcase
        if (flush) state_next = RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
            if (flush) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                head_reg  <= head_reg + n_commit[IDX_W-1:0];
                tail_reg  <= tail_reg + n_alloc[IDX_W-1:0];
                count_reg <= count_reg + n_alloc - n_commit;
            end
        end
    end

    // Writeback, then retirement, then allocation; the three never target the
    // same live slot, the ordering only matters for stale writebacks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < ROB_ENTRIES; e++) entries[e] <= '0;
        end else if (flush) begin
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                entries[e].valid <= 1'b0;
                entries[e].done  <= 1'b0;
                entries[e].exc   <= 1'b0;
            end
        end else begin
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                if (wb_set[e] && entries[e].valid) begin
                    entries[e].done <= 1'b1;
                    entries[e].exc  <= entries[e].exc | wb_exc[e];
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire[k]) entries[rob_commit_rob_idx[k]].valid <= 1'b0;
            end
            for (int i = 0; i < DISP_W; i++) begin
                if (alloc_fire[i]) begin
                    entries[alloc_rob_idx[i]].valid    <= 1'b1;
                    entries[alloc_rob_idx[i]].done     <= 1'b0;
                    entries[alloc_rob_idx[i]].exc      <= 1'b0;
                    entries[alloc_rob_idx[i]].is_store <= alloc_is_store[i];
                    entries[alloc_rob_idx[i]].arch_rd  <= alloc_arch_rd[i];
                    entries[alloc_rob_idx[i]].phys_rd  <= alloc_phys_rd[i];
                    entries[alloc_rob_idx[i]].pc       <= alloc_pc[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a per-cycle vector table plus hand
// sequences for fill/wrap and asynchronous reset.
module tb_reorder_buffer;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]            alloc_valid;
    logic [4:0]            alloc_arch_rd [2];
    logic [LOG2_PREGS-1:0] alloc_phys_rd [2];
    logic [XLEN-1:0]       alloc_pc [2];
    logic [1:0]            alloc_is_store;
    logic                  alloc_ready;
    logic [5:0]            alloc_rob_idx [2];
    logic [1:0]            wb_valid;
    logic [5:0]            wb_rob_idx [2];
    logic [1:0]            wb_exception;
    logic                  flush;
    logic [1:0]            rob_commit_valid;
    logic [4:0]            rob_commit_arch_rd [2];
    logic [LOG2_PREGS-1:0] rob_commit_phys_rd [2];
    logic [1:0]            rob_commit_exception;
    logic [5:0]            rob_commit_rob_idx [2];
    logic [1:0]            rob_commit_is_store;
    logic [XLEN-1:0]       rob_commit_pc [2];
    logic [6:0]            rob_count;
    logic                  rob_empty;
    logic                  rob_full;

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_arch_rd(alloc_arch_rd), .alloc_phys_rd(alloc_phys_rd),
        .alloc_pc(alloc_pc), .alloc_is_store(alloc_is_store), .alloc_ready(alloc_ready),
        .alloc_rob_idx(alloc_rob_idx), .wb_valid(wb_valid), .wb_rob_idx(wb_rob_idx),
        .wb_exception(wb_exception), .flush(flush), .rob_commit_valid(rob_commit_valid),
        .rob_commit_arch_rd(rob_commit_arch_rd), .rob_commit_phys_rd(rob_commit_phys_rd),
        .rob_commit_exception(rob_commit_exception), .rob_commit_rob_idx(rob_commit_rob_idx),
        .rob_commit_is_store(rob_commit_is_store), .rob_commit_pc(rob_commit_pc),
        .rob_count(rob_count), .rob_empty(rob_empty), .rob_full(rob_full)
    );

    typedef struct {
        logic [1:0] av;   logic [1:0] wbv;  logic [5:0] wi0;  logic [5:0] wi1;
        logic [1:0] we;   logic       fl;
        logic [1:0] cv;   logic [1:0] cexc; logic [5:0] cidx0; logic [6:0] cnt;
        logic       rdy;  logic [5:0] ai0;  logic [5:0] ai1;
    } vec_t;

    vec_t vecs [20];
    int checks = 0;
    int passes = 0;
    int seq = 0;

    logic [4:0]            sh_arch  [64];
    logic [LOG2_PREGS-1:0] sh_phys  [64];
    logic [XLEN-1:0]       sh_pc    [64];
    logic                  sh_store [64];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input logic [1:0] av, input logic [1:0] wbv, input logic [5:0] i0,
                         input logic [5:0] i1, input logic [1:0] we, input logic fl);
        alloc_valid  = av;
        wb_valid     = wbv;
        wb_rob_idx[0] = i0;
        wb_rob_idx[1] = i1;
        wb_exception = we;
        flush        = fl;
        for (int i = 0; i < 2; i++) begin
            int t;
            t = seq * 2 + i;
            alloc_arch_rd[i]  = 5'(t);
            alloc_phys_rd[i]  = LOG2_PREGS'(t + 10);
            alloc_pc[i]       = 32'h1000 + 32'(4 * t);
            alloc_is_store[i] = ((t % 3) == 0);
        end
        seq++;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    endtask

    task automatic chk_lane(input int r, input int k, input logic [5:0] idx);
        chk($sformatf("r%0d idx%0d", r, k), 64'(rob_commit_rob_idx[k]), 64'(idx));
        chk($sformatf("r%0d arch%0d", r, k), 64'(rob_commit_arch_rd[k]), 64'(sh_arch[idx]));
        chk($sformatf("r%0d phys%0d", r, k), 64'(rob_commit_phys_rd[k]), 64'(sh_phys[idx]));
        chk($sformatf("r%0d pc%0d", r, k), 64'(rob_commit_pc[k]), 64'(sh_pc[idx]));
        chk($sformatf("r%0d st%0d", r, k), 64'(rob_commit_is_store[k]), 64'(sh_store[idx]));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            av     wbv    wi0  wi1  we     fl    cv     cexc   cidx0 cnt   rdy   ai0  ai1
        vecs[0]  = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd0, 6'd1};
        vecs[1]  = '{2'b00, 2'b11, 6'd0, 6'd1, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd2, 1'b1, 6'd2, 6'd2};
        vecs[2]  = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b11, 2'b00, 6'd0, 7'd2, 1'b1, 6'd2, 6'd2};
        vecs[3]  = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd2, 6'd3};
        vecs[4]  = '{2'b00, 2'b01, 6'd3, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd2, 1'b1, 6'd4, 6'd4};
        vecs[5]  = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd2, 1'b1, 6'd4, 6'd4};
        vecs[6]  = '{2'b00, 2'b01, 6'd2, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd2, 1'b1, 6'd4, 6'd4};
        vecs[7]  = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b11, 2'b00, 6'd2, 7'd2, 1'b1, 6'd4, 6'd4};
        vecs[8]  = '{2'b10, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd4, 6'd4};
        vecs[9]  = '{2'b00, 2'b11, 6'd4, 6'd4, 2'b01, 1'b0, 2'b00, 2'b00, 6'd0, 7'd1, 1'b1, 6'd5, 6'd5};
        vecs[10] = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b01, 2'b01, 6'd4, 7'd1, 1'b1, 6'd5, 6'd5};
        vecs[11] = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd1, 1'b0, 6'd5, 6'd6};
        vecs[12] = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 7'd1, 1'b0, 6'd5, 6'd6};
        vecs[13] = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd0, 6'd1};
        vecs[14] = '{2'b00, 2'b11, 6'd0, 6'd1, 2'b10, 1'b0, 2'b00, 2'b00, 6'd0, 7'd2, 1'b1, 6'd2, 6'd2};
        vecs[15] = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b01, 2'b00, 6'd0, 7'd2, 1'b1, 6'd2, 6'd2};
        vecs[16] = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b01, 2'b01, 6'd1, 7'd1, 1'b1, 6'd2, 6'd2};
        vecs[17] = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 7'd1, 1'b0, 6'd2, 6'd2};
        vecs[18] = '{2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd0, 6'd1};
        vecs[19] = '{2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0, 2'b00, 2'b00, 6'd0, 7'd0, 1'b1, 6'd0, 6'd0};

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset count", 64'(rob_count), 64'd0);
        chk("reset ready", 64'(alloc_ready), 64'd1);
        chk("reset cvalid", 64'(rob_commit_valid), 64'd0);
        chk("reset empty", 64'(rob_empty), 64'd1);
        chk("reset full", 64'(rob_full), 64'd0);

        for (int r = 0; r < 20; r++) begin
            @(negedge clk);
            drive(vecs[r].av, vecs[r].wbv, vecs[r].wi0, vecs[r].wi1, vecs[r].we, vecs[r].fl);
            #1;
            $display("row %0d: av=%b wbv=%b fl=%b cv=%b cnt=%0d rdy=%b", r, vecs[r].av,
                     vecs[r].wbv, vecs[r].fl, rob_commit_valid, rob_count, alloc_ready);
            chk($sformatf("r%0d count", r), 64'(rob_count), 64'(vecs[r].cnt));
            chk($sformatf("r%0d ready", r), 64'(alloc_ready), 64'(vecs[r].rdy));
            chk($sformatf("r%0d aidx0", r), 64'(alloc_rob_idx[0]), 64'(vecs[r].ai0));
            chk($sformatf("r%0d aidx1", r), 64'(alloc_rob_idx[1]), 64'(vecs[r].ai1));
            chk($sformatf("r%0d cvalid", r), 64'(rob_commit_valid), 64'(vecs[r].cv));
            chk($sformatf("r%0d cexc", r), 64'(rob_commit_exception & rob_commit_valid),
                64'(vecs[r].cexc));
            chk($sformatf("r%0d empty", r), 64'(rob_empty), 64'(vecs[r].cnt == 7'd0));
            if (vecs[r].cv[0]) chk_lane(r, 0, vecs[r].cidx0);
            if (vecs[r].cv[1]) chk_lane(r, 1, vecs[r].cidx0 + 6'd1);
            if (vecs[r].rdy && !vecs[r].fl) begin
                for (int i = 0; i < 2; i++) begin
                    if (vecs[r].av[i]) begin
                        logic [5:0] ix;
                        ix = (i == 0) ? vecs[r].ai0 : vecs[r].ai1;
                        sh_arch[ix]  = alloc_arch_rd[i];
                        sh_phys[ix]  = alloc_phys_rd[i];
                        sh_pc[ix]    = alloc_pc[i];
                        sh_store[ix] = alloc_is_store[i];
                    end
                end
            end
        end

        // Fill to 64 entries, commit at full, then wrap the tail back to 0.
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
            #1;
            chk($sformatf("fill%0d ready", c), 64'(alloc_ready), 64'd1);
            chk($sformatf("fill%0d count", c), 64'(rob_count), 64'(2 * c));
        end
        @(negedge clk);
        drive(2'b11, 2'b01, 6'd0, 6'd0, 2'b00, 1'b0);
        #1;
        $display("full: cnt=%0d rdy=%b full=%b", rob_count, alloc_ready, rob_full);
        chk("full count", 64'(rob_count), 64'd64);
        chk("full flag", 64'(rob_full), 64'd1);
        chk("full ready", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("full commit count", 64'(rob_count), 64'd64);
        chk("full commit cvalid", 64'(rob_commit_valid), 64'd1);
        chk("full commit ready", 64'(alloc_ready), 64'd0);
        @(negedge clk);
        drive(2'b00, 2'b11, 6'd1, 6'd2, 2'b00, 1'b0);
        #1;
        $display("count63: cnt=%0d rdy=%b full=%b", rob_count, alloc_ready, rob_full);
        chk("c63 count", 64'(rob_count), 64'd63);
        chk("c63 ready", 64'(alloc_ready), 64'd0);
        chk("c63 full", 64'(rob_full), 64'd0);
        chk("c63 cvalid", 64'(rob_commit_valid), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("c63 commit2", 64'(rob_commit_valid), 64'd3);
        chk("c63 commit idx", 64'(rob_commit_rob_idx[0]), 64'd1);
        @(negedge clk);
        drive(2'b01, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
        #1;
        $display("wrap: cnt=%0d rdy=%b aidx0=%0d", rob_count, alloc_ready, alloc_rob_idx[0]);
        chk("wrap count", 64'(rob_count), 64'd61);
        chk("wrap ready", 64'(alloc_ready), 64'd1);
        chk("wrap aidx0", 64'(alloc_rob_idx[0]), 64'd0);
        @(negedge clk);
        idle();
        #1;
        chk("wrap after", 64'(rob_count), 64'd62);
        chk("wrap aidx next", 64'(alloc_rob_idx[0]), 64'd1);

        // Flush, build up 10 entries, then reset in the middle of a cycle.
        @(negedge clk);
        drive(2'b00, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            drive(2'b11, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        chk("pre-reset count", 64'(rob_count), 64'd10);
        #2;
        reset = 1'b1;
        #1;
        $display("mid reset: cnt=%0d rdy=%b empty=%b", rob_count, alloc_ready, rob_empty);
        chk("areset count", 64'(rob_count), 64'd0);
        chk("areset empty", 64'(rob_empty), 64'd1);
        chk("areset ready", 64'(alloc_ready), 64'd1);
        chk("areset cvalid", 64'(rob_commit_valid), 64'd0);
        chk("areset aidx0", 64'(alloc_rob_idx[0]), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset count", 64'(rob_count), 64'd0);
        chk("post-reset full", 64'(rob_full), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
